// File: rtl/recur_update_engine.sv
// Handshaked update engine for the a/b/c/d recurrence with selectable
// parallel (all-at-once) or sequential (one assignment per cycle) semantics.
module recur_update_engine #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8,
   parameter int SUB_K = 3,
   parameter int ADD_K = 10,
   parameter int INC_K = 1
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [CNT_W-1:0] iters,
   input  logic [WIDTH-1:0] init_a,
   input  logic [WIDTH-1:0] init_b,
   input  logic [WIDTH-1:0] init_c,
   input  logic [WIDTH-1:0] init_d,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] iter_cnt
);

   localparam logic [WIDTH-1:0] SUB_C = WIDTH'(SUB_K);
   localparam logic [WIDTH-1:0] ADD_C = WIDTH'(ADD_K);
   localparam logic [WIDTH-1:0] INC_C = WIDTH'(INC_K);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nx;
   logic             mode_r;
   logic [CNT_W-1:0] iters_r;
   logic [1:0]       phase;
   logic             last_step;

   // True on the edge that completes iteration number iters_r.
   always_comb begin
      last_step = 1'b0;
      if ((iter_cnt + CNT_W'(1)) == iters_r)
         last_step = !mode_r || (phase == 2'd3);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // A zero-iteration run enters FIN with done still low; done rises one
   // edge later so the pulse lands between T1 and T2 like a normal finish.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = (iters == '0) ? FIN : RUN;
         RUN:  if (last_step) state_nx = FIN;
         FIN:  if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         a        <= '0;
         b        <= '0;
         c        <= '0;
         d        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         iter_cnt <= '0;
         phase    <= '0;
         mode_r   <= 1'b0;
         iters_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a        <= init_a;
                  b        <= init_b;
                  c        <= init_c;
                  d        <= init_d;
                  mode_r   <= mode;
                  iters_r  <= iters;
                  iter_cnt <= '0;
                  phase    <= '0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (!mode_r) begin
                  a        <= b + c;
                  d        <= a - SUB_C;
                  b        <= d + ADD_C;
                  c        <= c + INC_C;
                  iter_cnt <= iter_cnt + CNT_W'(1);
               end else begin
                  case (phase)
                     2'd0: a <= b + c;
                     2'd1: d <= a - SUB_C;
                     2'd2: b <= d + ADD_C;
                     default: begin
                        c        <= c + INC_C;
                        iter_cnt <= iter_cnt + CNT_W'(1);
                     end
                  endcase
                  phase <= phase + 2'd1;
               end
               if (last_step) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
            FIN: begin
               if (!done) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  done <= 1'b0;
               end
            end
            default: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_recur_update_engine.sv
// Scoreboard bench for recur_update_engine: reference recurrence model,
// latency/pulse checks, wrap at WIDTH=8, and asynchronous abort.
module tb_recur_update_engine;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  iters = '0;
   logic [31:0] init_a = '0, init_b = '0, init_c = '0, init_d = '0;
   logic [31:0] a, b, c, d;
   logic        busy, done;
   logic [7:0]  iter_cnt;

   logic        start8 = 1'b0;
   logic        mode8 = 1'b0;
   logic [7:0]  iters8 = '0;
   logic [7:0]  init8_a = '0, init8_b = '0, init8_c = '0, init8_d = '0;
   logic [7:0]  a8, b8, c8, d8;
   logic        busy8, done8;
   logic [7:0]  cnt8;

   int unsigned n_run = 0;
   int unsigned n_fail = 0;

   typedef struct {
      logic [31:0] a, b, c, d;
      int          iter;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] a, b, c, d;
   } snap_t;

   exp_t  sb[$];
   snap_t trace[$];

   always #5 clock = ~clock;

   recur_update_engine u_dut (
      .clock(clock), .rst_n(rst_n), .start(start), .mode(mode), .iters(iters),
      .init_a(init_a), .init_b(init_b), .init_c(init_c), .init_d(init_d),
      .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .iter_cnt(iter_cnt)
   );

   recur_update_engine #(.WIDTH(8)) u_dut8 (
      .clock(clock), .rst_n(rst_n), .start(start8), .mode(mode8), .iters(iters8),
      .init_a(init8_a), .init_b(init8_b), .init_c(init8_c), .init_d(init8_d),
      .a(a8), .b(b8), .c(c8), .d(d8), .busy(busy8), .done(done8), .iter_cnt(cnt8)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input bit m, input int n,
                                  input logic [31:0] ia, ib, ic, id);
      exp_t e;
      logic [31:0] ra, rb, rc, rd, na, nb, nd;
      ra = ia; rb = ib; rc = ic; rd = id;
      for (int i = 0; i < n; i++) begin
         if (m) begin
            ra = rb + rc;
            rd = ra - 32'd3;
            rb = rd + 32'd10;
            rc = rc + 32'd1;
         end else begin
            na = rb + rc;
            nd = ra - 32'd3;
            nb = rd + 32'd10;
            rc = rc + 32'd1;
            ra = na; rd = nd; rb = nb;
         end
      end
      e.a = ra; e.b = rb; e.c = rc; e.d = rd;
      e.iter = n;
      e.lat  = (n == 0) ? 1 : (m ? 4 * n : n);
      return e;
   endfunction

   // Must be called just after a negedge; leaves on the negedge after done falls.
   task automatic run_op(input bit m, input int n,
                         input logic [31:0] ia, ib, ic, id, input bit poke);
      exp_t e, got_e;
      bit   seen;
      int   busy_cnt;
      e = model(m, n, ia, ib, ic, id);
      sb.push_back(e);
      start = 1'b1; mode = m; iters = n[7:0];
      init_a = ia; init_b = ib; init_c = ic; init_d = id;
      @(posedge clock);
      #1;
      start = 1'b0; mode = ~m; iters = 8'd7;
      init_a = 32'hdead; init_b = 32'hbeef; init_c = 32'h1234; init_d = 32'h5678;
      seen = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k <= e.lat + 20 && !seen; k++) begin
         @(negedge clock);
         if (poke && k == 1) start = 1'b1;
         if (poke && k == 2) start = 1'b0;
         if (busy) busy_cnt++;
         if (k >= 1 && k <= trace.size()) begin
            check_eq($sformatf("trace%0d_a", k), a, trace[k-1].a);
            check_eq($sformatf("trace%0d_b", k), b, trace[k-1].b);
            check_eq($sformatf("trace%0d_c", k), c, trace[k-1].c);
            check_eq($sformatf("trace%0d_d", k), d, trace[k-1].d);
         end
         if (done) begin
            seen = 1'b1;
            got_e = sb.pop_front();
            check_eq("final_a", a, got_e.a);
            check_eq("final_b", b, got_e.b);
            check_eq("final_c", c, got_e.c);
            check_eq("final_d", d, got_e.d);
            check_eq("iter_cnt", iter_cnt, got_e.iter);
            check_eq("latency", k, got_e.lat);
            check_eq("busy_at_done", busy, 0);
            check_eq("busy_cycles", busy_cnt, (n == 0) ? 1 : got_e.lat);
         end
      end
      if (!seen) begin
         check_eq("done_timeout", 0, 1);
         void'(sb.pop_front());
      end
      start = 1'b0;
      @(negedge clock);
      check_eq("done_width", done, 0);
      check_eq("busy_after", busy, 0);
      trace.delete();
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check_eq("rst_a", a, 0);
      check_eq("rst_b", b, 0);
      check_eq("rst_c", c, 0);
      check_eq("rst_d", d, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_cnt", iter_cnt, 0);
      rst_n = 1'b1;
      @(negedge clock);

      trace.push_back('{32'd35, 32'd15, 32'd16, 32'd27});
      trace.push_back('{32'd31, 32'd37, 32'd17, 32'd32});
      run_op(1'b0, 2, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
      check_eq("t1_a", a, 31);
      check_eq("t1_b", b, 37);

      trace.push_back('{32'd35, 32'd20, 32'd15, 32'd5});
      trace.push_back('{32'd35, 32'd20, 32'd15, 32'd32});
      trace.push_back('{32'd35, 32'd42, 32'd15, 32'd32});
      trace.push_back('{32'd35, 32'd42, 32'd16, 32'd32});
      run_op(1'b1, 2, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
      check_eq("t2_a", a, 58);
      check_eq("t2_d", d, 55);
      check_eq("t2_b", b, 65);
      check_eq("t2_c", c, 17);

      run_op(1'b0, 10, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);
      check_eq("t3_a", a, 119);
      check_eq("t3_d", d, 108);

      run_op(1'b0, 0, 32'd7, 32'd8, 32'd9, 32'd10, 1'b0);
      run_op(1'b0, 4, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
      run_op(1'b1, 3, 32'hffff_fff0, 32'd2, 32'hffff_ffff, 32'd1, 1'b1);
      run_op(1'b1, 0, 32'd11, 32'd12, 32'd13, 32'd14, 1'b0);
      for (int i = 0; i < 3; i++)
         run_op(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
                $urandom, $urandom, $urandom, $urandom, 1'b0);

      start8 = 1'b1; mode8 = 1'b0; iters8 = 8'd1;
      init8_a = 8'd0; init8_b = 8'd250; init8_c = 8'd10; init8_d = 8'd0;
      @(posedge clock);
      #1 start8 = 1'b0;
      @(negedge clock);
      check_eq("w8_busy", busy8, 1);
      @(negedge clock);
      check_eq("w8_done", done8, 1);
      check_eq("w8_a", a8, 4);
      check_eq("w8_d", d8, 253);
      check_eq("w8_b", b8, 10);
      check_eq("w8_c", c8, 11);
      check_eq("w8_cnt", cnt8, 1);
      @(negedge clock);

      start = 1'b1; mode = 1'b1; iters = 8'd5;
      init_a = 32'd30; init_b = 32'd20; init_c = 32'd15; init_d = 32'd5;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (6) @(negedge clock);
      check_eq("pre_abort_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_a", a, 0);
      check_eq("abort_b", b, 0);
      check_eq("abort_c", c, 0);
      check_eq("abort_d", d, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_cnt", iter_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_eq("abort_no_done", done, 0);
      end
      rst_n = 1'b1;
      @(negedge clock);
      check_eq("abort_idle_done", done, 0);
      run_op(1'b1, 2, 32'd30, 32'd20, 32'd15, 32'd5, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
